// File: rtl/plotter_pkg.sv
// Shared definitions for the character read-out path: reader FSM states and
// default buffer geometry.
package plotter_pkg;

  localparam int CHAR_W_DEFAULT = 6;
  localparam int DEPTH_DEFAULT  = 100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_PRESENT,
    ST_DONE
  } reader_state_t;

endpackage

// File: rtl/read_index_counter.sv
// Read index register for the character buffer: synchronous clear, increment
// on enable, saturating at the last buffer slot so it can never wrap.
module read_index_counter #(
  parameter int DEPTH = 100,
  parameter int IDX_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [IDX_W-1:0] count
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  // NOTE: sequential state is only ever assigned with <= so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/char_reader.sv
// Reads characters out of an externally written buffer, one index at a time,
// and hands them to a consumer over a valid/ready handshake.
module char_reader
  import plotter_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  write_index,
  input  logic              eof_in,
  input  logic [CHAR_W-1:0] curr_char,
  output logic [IDX_W-1:0]  select,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W:0]   DEPTH_X = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  reader_state_t state_q, state_d;

  logic           idx_clear;
  logic           idx_inc;
  logic           load_char;
  logic           drop_valid;
  logic [IDX_W:0] avail;
  logic           has_char;

  // A writer count beyond the buffer size is clamped so the reader stops at
  // the last slot instead of chasing indices that do not exist.
  assign avail    = ({1'b0, write_index} > DEPTH_X) ? DEPTH_X : {1'b0, write_index};
  assign has_char = ({1'b0, select} < avail);

  read_index_counter #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_index (
    .clock  (clock),
    .reset  (reset),
    .clear  (idx_clear),
    .enable (idx_inc),
    .count  (select)
  );

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_clear  = 1'b0;
    idx_inc    = 1'b0;
    load_char  = 1'b0;
    drop_valid = 1'b0;

    if (start) begin
      // A start from any state restarts the read-out from index 0.
      state_d    = ST_WAIT;
      idx_clear  = 1'b1;
      drop_valid = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_WAIT: begin
          if (has_char) begin
            state_d = ST_FETCH;
          end else if (eof_in) begin
            state_d = ST_DONE;
          end
        end
        ST_FETCH: begin
          load_char = 1'b1;
          state_d   = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (char_valid && char_ready) begin
            drop_valid = 1'b1;
            if (select == LAST) begin
              state_d = ST_DONE;
            end else begin
              idx_inc = 1'b1;
              state_d = ST_WAIT;
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      char_out   <= '0;
      char_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == ST_DONE);
      if (load_char) begin
        char_out   <= curr_char;
        char_valid <= 1'b1;
      end else if (drop_valid) begin
        char_valid <= 1'b0;
      end
    end
  end

  assign busy = !((state_q == ST_IDLE) || (state_q == ST_DONE));

endmodule

// File: tb/tb_char_reader.sv
// Directed bench for char_reader: a behavioural buffer feeds curr_char and a
// scoreboard of expected (char, index) pairs is checked on every transfer.
module tb_char_reader;

  localparam int CW = 6;
  localparam int D  = 100;
  localparam int IW = 7;

  typedef struct {
    logic [CW-1:0] ch;
    logic [IW-1:0] idx;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] write_index;
  logic          eof_in;
  logic [CW-1:0] curr_char;
  logic [IW-1:0] select;
  logic [CW-1:0] char_out;
  logic          char_valid;
  logic          char_ready;
  logic          busy;
  logic          done;

  logic [CW-1:0] mem [D];
  exp_t          sb [$];

  int checks       = 0;
  int errors       = 0;
  int xfers        = 0;
  int valid_cycles = 0;

  always #5 clock = ~clock;

  assign curr_char = mem[select];

  char_reader #(.CHAR_W(CW), .DEPTH(D), .IDX_W(IW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .write_index (write_index),
    .eof_in      (eof_in),
    .curr_char   (curr_char),
    .select      (select),
    .char_out    (char_out),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_range(input int first, input int last);
    exp_t e;
    for (int i = first; i <= last; i++) begin
      e.ch  = mem[i];
      e.idx = IW'(i);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!char_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(char_valid), 32'd1);
  endtask

  // Transfer monitor: a handshake counts only when neither reset nor start
  // overrides it on the coming edge.
  always @(negedge clock) begin
    exp_t e;
    if (char_valid) valid_cycles++;
    if (!reset && !start && char_valid && char_ready) begin
      xfers++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("xfer_char", 32'(char_out), 32'(e.ch));
        check("xfer_idx", 32'(select), 32'(e.idx));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    write_index = '0;
    eof_in      = 1'b0;
    char_ready  = 1'b0;
    for (int i = 0; i < D; i++) mem[i] = CW'($urandom_range(0, 63));

    // Reset state
    tick();
    tick();
    check("rst_select", 32'(select), 32'd0);
    check("rst_char_out", 32'(char_out), 32'd0);
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Empty buffer with eof: DONE two edges after start, never valid
    eof_in = 1'b1;
    valid_cycles = 0;
    pulse_start();
    check("empty_busy", 32'(busy), 32'd1);
    check("empty_done_early", 32'(done), 32'd0);
    tick();
    check("empty_done", 32'(done), 32'd1);
    check("empty_busy_off", 32'(busy), 32'd0);
    check("empty_no_valid", 32'(valid_cycles), 32'd0);

    // Three chars, consumer always ready
    mem[0] = 6'h01; mem[1] = 6'h02; mem[2] = 6'h03;
    write_index = 7'd3;
    char_ready  = 1'b1;
    push_range(0, 2);
    xfers = 0;
    valid_cycles = 0;
    pulse_start();
    check("three_done_cleared", 32'(done), 32'd0);
    wait_done("three_done", 30);
    check("three_xfers", 32'(xfers), 32'd3);
    check("three_valid_cycles", 32'(valid_cycles), 32'd3);
    check("three_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: output held while consumer stalls
    mem[0] = 6'h15; mem[1] = 6'h2B;
    write_index = 7'd2;
    char_ready  = 1'b0;
    push_range(0, 1);
    xfers = 0;
    pulse_start();
    wait_valid("stall_valid", 10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_char", 32'(char_out), 32'h15);
      check("stall_select", 32'(select), 32'd0);
      check("stall_valid_held", 32'(char_valid), 32'd1);
    end
    check("stall_no_xfer", 32'(xfers), 32'd0);
    char_ready = 1'b1;
    wait_done("stall_done", 30);
    check("stall_xfers", 32'(xfers), 32'd2);
    check("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Reader waits on an empty buffer until the writer catches up
    write_index = '0;
    eof_in      = 1'b0;
    xfers = 0;
    valid_cycles = 0;
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_select", 32'(select), 32'd0);
    check("wait_no_valid", 32'(valid_cycles), 32'd0);
    mem[0] = 6'h2A;
    write_index = 7'd1;
    push_range(0, 0);
    for (int i = 0; i < 10; i++) tick();
    check("wait_xfer", 32'(xfers), 32'd1);
    check("wait_not_done", 32'(done), 32'd0);
    check("wait_still_busy", 32'(busy), 32'd1);
    eof_in = 1'b1;
    wait_done("wait_done", 10);
    check("wait_sb_empty", 32'(sb.size()), 32'd0);

    // Full buffer: 100 transfers, stop at the last slot
    for (int i = 0; i < D; i++) mem[i] = CW'($urandom_range(0, 63));
    write_index = 7'd100;
    push_range(0, D - 1);
    xfers = 0;
    pulse_start();
    wait_done("full_done", 400);
    check("full_xfers", 32'(xfers), 32'd100);
    check("full_last_select", 32'(select), 32'd99);
    check("full_sb_empty", 32'(sb.size()), 32'd0);

    // Oversized write count is clamped; DONE reached without eof
    write_index = 7'd127;
    eof_in      = 1'b0;
    push_range(0, D - 1);
    xfers = 0;
    pulse_start();
    wait_done("clamp_done", 400);
    check("clamp_xfers", 32'(xfers), 32'd100);
    check("clamp_select", 32'(select), 32'd99);
    check("clamp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while a char is presented, overriding start and ready
    write_index = 7'd3;
    eof_in      = 1'b1;
    char_ready  = 1'b0;
    pulse_start();
    wait_valid("rstp_valid", 10);
    reset      = 1'b1;
    start      = 1'b1;
    char_ready = 1'b1;
    tick();
    check("rstp_valid_low", 32'(char_valid), 32'd0);
    check("rstp_select", 32'(select), 32'd0);
    check("rstp_busy", 32'(busy), 32'd0);
    check("rstp_done", 32'(done), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("rstp_idle", 32'(busy), 32'd0);
    push_range(0, 2);
    xfers = 0;
    pulse_start();
    wait_done("rstp_replay_done", 30);
    check("rstp_replay_xfers", 32'(xfers), 32'd3);
    check("rstp_sb_empty", 32'(sb.size()), 32'd0);

    // Restart mid-read at select 5: next delivery is index 0
    write_index = 7'd10;
    push_range(0, 9);
    pulse_start();
    begin
      int n = 0;
      while (select != 7'd5 && n < 50) begin
        tick();
        n++;
      end
    end
    check("restart_reach5", 32'(select), 32'd5);
    sb.delete();
    push_range(0, 9);
    xfers = 0;
    pulse_start();
    check("restart_select", 32'(select), 32'd0);
    wait_done("restart_done", 60);
    check("restart_xfers", 32'(xfers), 32'd10);
    check("restart_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_reader.md
CHAR_READER -- requirements
Module: char_reader

Interface
REQ-001 SHALL have parameter CHAR_W, default 6, character width in bits.
REQ-002 SHALL have parameter DEPTH, default 100, buffer capacity in characters.
REQ-003 SHALL have parameter IDX_W, default 7, index width (ceil(log2(DEPTH))).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse, begin read-out from index 0.
REQ-007 SHALL have port write_index  in  IDX_W  count of characters written into the buffer, synchronous to clock.
REQ-008 SHALL have port eof_in  in  1  level, writer has seen end-of-file.
REQ-009 SHALL have port curr_char  in  CHAR_W  buffer data at select, combinational from buffer.
REQ-010 SHALL have port select  out  IDX_W  read index driven to the buffer.
REQ-011 SHALL have port char_out  out  CHAR_W  registered character to consumer.
REQ-012 SHALL have port char_valid  out  1  char_out holds a character.
REQ-013 SHALL have port char_ready  in  1  consumer accepts char_out this cycle.
REQ-014 SHALL have port busy  out  1  high in any state except IDLE and DONE.
REQ-015 SHALL have port done  out  1  level, read-out complete, until next start or reset.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, FETCH, PRESENT, DONE.
REQ-017 IDLE: on start, select<=0, go WAIT.
REQ-018 WAIT: if select < min(write_index, DEPTH) go FETCH; else if eof_in go DONE; else stay.
REQ-019 FETCH: one cycle for combinational buffer read to settle; at end, char_out<=curr_char, char_valid<=1, go PRESENT.
REQ-020 PRESENT: hold char_out and char_valid stable until char_valid && char_ready; transfer occurs on that edge.
REQ-021 On transfer: char_valid<=0; if select == DEPTH-1 go DONE; else select<=select+1, go WAIT.
REQ-022 Latency: char visible on char_out 2 cycles after WAIT sees select < write_index; max throughput one char per 3 cycles.
REQ-023 char_ready while char_valid low SHALL have no effect.
REQ-024 start while busy or in DONE SHALL restart: select<=0, char_valid<=0, done<=0, go WAIT.
REQ-025 start with write_index==0 and eof_in high SHALL reach DONE in 2 cycles with no char_valid.
REQ-026 write_index > DEPTH SHALL be treated as DEPTH; select SHALL never exceed DEPTH-1 (no wrap).
REQ-027 write_index falling to <= select SHALL hold the reader in WAIT; no underflow.
REQ-028 eof_in rising while chars remain SHALL not truncate; all indices < write_index are delivered first.
REQ-029 done SHALL be 1 only in DONE; busy SHALL equal !(IDLE || DONE).

Reset
REQ-030 On reset: state IDLE, select=0, char_out=0, char_valid=0, done=0, busy=0.
REQ-031 reset SHALL override start and char_ready in the same cycle; in-flight char is discarded.

Structure
REQ-032 State enum, CHAR_W and DEPTH defaults SHALL live in shared package plotter_pkg.
REQ-033 select increment/clear SHALL be one sub-module read_index_counter (clear, enable, saturate at DEPTH-1).
REQ-034 Only char_out, char_valid, select, done and state SHALL be registered; busy is decoded from state.

Verification
REQ-035 Write 3 chars (0x01,0x02,0x03), eof_in=1, start, char_ready=1 -> char_out 0x01,0x02,0x03 each 1 valid cycle, done=1 after third transfer.
REQ-036 char_ready=0 for 5 cycles while char_valid=1 -> char_out/select constant; single transfer when ready rises.
REQ-037 write_index=0, eof_in=0, start; after 10 cycles write_index=1 char 0x2A -> WAIT held, then 0x2A delivered; done only after eof_in=1.
REQ-038 write_index=100, char_ready=1 -> 100 transfers, last select=99, DONE, no wrap to 0.
REQ-039 reset asserted in PRESENT -> next cycle char_valid=0, select=0, state IDLE; start then replays from index 0.
REQ-040 start pulsed mid-read at select=5 -> next char delivered is index 0.
